// File: rtl/motor_feedback_rx.sv
// motor_feedback_rx: 8N1 UART receiver and packet framer for the motor base
// feedback stream; latches payload bytes 0..2 of checksum-verified packets.
module motor_feedback_rx #(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] HEADER       = 8'h13,
   parameter int         MAX_LEN      = 16,
   parameter int         TIMEOUT_BITS = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_in,
   output logic [7:0]  pkt_id,
   output logic [15:0] pkt_data,
   output logic        frame_valid,
   output logic        frame_error,
   output logic        busy
);
   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int TMO = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW  = $clog2(TMO);
   localparam int IW  = $clog2(MAX_LEN + 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TMO_END  = TW'(TMO - 1);
   localparam logic [7:0]    MAX_B    = 8'(MAX_LEN);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_t;
   typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} ps_t;

   logic          sync1, sync2, rx_prev;
   rx_t           rstate, rnext;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg, byte_q;
   logic          byte_stb, stop_err;
   logic          cnt_clr, take_bit, stop_ok, stop_bad;

   ps_t           pstate, pnext;
   logic [TW-1:0] tcnt;
   logic [7:0]    len, sum, csum, sh0, sh1, sh2;
   logic [IW-1:0] idx;
   logic          tmo, last, good, perr;

   always_comb begin
      rnext    = rstate;
      cnt_clr  = 1'b0;
      take_bit = 1'b0;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      unique case (rstate)
         IDLE: begin
            if (rx_prev && !sync2) begin
               rnext   = START;
               cnt_clr = 1'b1;
            end
         end
         START: begin
            // mid start bit: a high line means the edge was a glitch
            if (cnt == HALF_END) begin
               cnt_clr = 1'b1;
               rnext   = sync2 ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_END) begin
               cnt_clr  = 1'b1;
               take_bit = 1'b1;
               if (bit_idx == 3'd7) rnext = STOP;
            end
         end
         STOP: begin
            if (cnt == BIT_END) begin
               rnext    = IDLE;
               stop_ok  = sync2;
               stop_bad = !sync2;
            end
         end
         default: rnext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         rx_prev  <= 1'b1;
         rstate   <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         byte_q   <= '0;
         byte_stb <= 1'b0;
         stop_err <= 1'b0;
      end else begin
         sync1    <= uart_in;
         sync2    <= sync1;
         rx_prev  <= sync2;
         rstate   <= rnext;
         cnt      <= cnt_clr ? '0 : cnt + 1'b1;
         byte_stb <= stop_ok;
         stop_err <= stop_bad;
         if (rstate != DATA) bit_idx <= '0;
         if (take_bit) begin
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
         end
         if (stop_ok) byte_q <= shreg;
      end
   end

   assign csum = sum + byte_q;
   assign last = (8'(idx) == len - 8'd1);
   assign tmo  = (pstate != HUNT) && (rstate == IDLE) && (tcnt == TMO_END);
   assign busy = (pstate != HUNT);

   always_comb begin
      pnext = pstate;
      good  = 1'b0;
      perr  = 1'b0;
      if (stop_err || tmo) begin
         pnext = HUNT;
         perr  = 1'b1;
      end else if (byte_stb) begin
         unique case (pstate)
            HUNT:    if (byte_q == HEADER) pnext = LEN;
            LEN: begin
               if (byte_q == 8'd0 || byte_q > MAX_B) begin
                  perr  = 1'b1;
                  pnext = HUNT;
               end else begin
                  pnext = PAYLOAD;
               end
            end
            PAYLOAD: if (last) pnext = CSUM;
            CSUM: begin
               pnext = HUNT;
               good  = (csum == 8'h00);
               perr  = (csum != 8'h00);
            end
            default: pnext = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pstate      <= HUNT;
         tcnt        <= '0;
         len         <= '0;
         sum         <= '0;
         idx         <= '0;
         sh0         <= '0;
         sh1         <= '0;
         sh2         <= '0;
         pkt_id      <= '0;
         pkt_data    <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         pstate      <= pnext;
         frame_valid <= good;
         frame_error <= perr;
         if (pstate == HUNT || rstate != IDLE || byte_stb) tcnt <= '0;
         else tcnt <= tcnt + 1'b1;
         if (byte_stb) begin
            case (pstate)
               HUNT: sum <= HEADER;
               LEN: begin
                  len <= byte_q;
                  sum <= csum;
                  idx <= '0;
                  sh0 <= '0;
                  sh1 <= '0;
                  sh2 <= '0;
               end
               PAYLOAD: begin
                  sum <= csum;
                  idx <= idx + 1'b1;
                  if (idx == IW'(0)) sh0 <= byte_q;
                  if (idx == IW'(1)) sh1 <= byte_q;
                  if (idx == IW'(2)) sh2 <= byte_q;
               end
               default: ;
            endcase
         end
         if (good) begin
            pkt_id   <= sh0;
            pkt_data <= {sh1, sh2};
         end
      end
   end
endmodule

// File: tb/tb_motor_feedback_rx.sv
// tb_motor_feedback_rx: directed and randomized packet traffic checked
// against a packet-level reference model.
module tb_motor_feedback_rx;
   localparam int CPB  = 8;
   localparam int MAXL = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_in = 1'b1;
   logic [7:0]  pkt_id;
   logic [15:0] pkt_data;
   logic        frame_valid, frame_error, busy;

   int checks = 0;
   int failures = 0;
   int nv = 0, ne = 0, nv0 = 0, ne0 = 0;
   logic [7:0]  exp_id = '0;
   logic [15:0] exp_data = '0;
   logic [7:0]  pq[$];

   motor_feedback_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst(rst),
      .uart_in(uart_in),
      .pkt_id(pkt_id),
      .pkt_data(pkt_data),
      .frame_valid(frame_valid),
      .frame_error(frame_error),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (frame_valid) nv++;
      if (frame_error) ne++;
      if (frame_valid || frame_error)
         chk("pulse_excl", 32'(frame_valid & frame_error), 32'd0);
   end

   task automatic send_byte(input logic [7:0] b, input bit stop_hi);
      uart_in = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_in = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_in = stop_hi;
      repeat (CPB) @(negedge clk);
      uart_in = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic send_q(input logic [7:0] q[$]);
      foreach (q[i]) begin
         send_byte(q[i], 1'b1);
         idle_bits($urandom_range(0, 2));
      end
   endtask

   task automatic expect_result(input string tag, input int dv, input int de);
      idle_bits(3);
      chk({tag, "_valid"}, nv - nv0, dv);
      chk({tag, "_err"}, ne - ne0, de);
      chk({tag, "_id"}, 32'(pkt_id), 32'(exp_id));
      chk({tag, "_data"}, 32'(pkt_data), 32'(exp_data));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      nv0 = nv;
      ne0 = ne;
   endtask

   // Packet-level model: a frame is good when its length is legal and
   // all bytes from header to checksum add to a multiple of 256.
   function automatic void ref_model(input logic [7:0] p[$],
                                     output int v, output int e);
      int n, s;
      n = int'(p[1]);
      s = 0;
      v = 0;
      e = 1;
      if (n >= 1 && n <= MAXL) begin
         for (int i = 0; i < n + 3; i++) s += int'(p[i]);
         if (s % 256 == 0) begin
            v = 1;
            e = 0;
            exp_id   = p[2];
            exp_data = {(n > 1) ? p[3] : 8'h00, (n > 2) ? p[4] : 8'h00};
         end
      end
   endfunction

   initial begin
      int ev, ee;
      repeat (5) @(negedge clk);
      chk("rst_id", 32'(pkt_id), 32'd0);
      chk("rst_data", 32'(pkt_data), 32'd0);
      chk("rst_fv", 32'(frame_valid), 32'd0);
      chk("rst_fe", 32'(frame_error), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      idle_bits(2);

      pq = {8'h13, 8'h03, 8'h07, 8'h12, 8'h34, 8'h9D};
      send_q(pq);
      exp_id = 8'h07; exp_data = 16'h1234;
      expect_result("good", 1, 0);

      pq = {8'h55, 8'hAA, 8'h13, 8'h01, 8'h42, 8'hAA};
      send_q(pq);
      exp_id = 8'h42; exp_data = 16'h0000;
      expect_result("short", 1, 0);

      pq = {8'h13, 8'h03, 8'h07, 8'h12, 8'h34, 8'h9E};
      send_q(pq);
      expect_result("badsum", 0, 1);

      pq = {8'h13, 8'h03, 8'h07, 8'h12, 8'h34, 8'h9D};
      send_q(pq);
      exp_id = 8'h07; exp_data = 16'h1234;
      expect_result("after_bad", 1, 0);

      pq = {8'h13, 8'h00};
      send_q(pq);
      expect_result("len0", 0, 1);
      pq = {8'h13, 8'h11};
      send_q(pq);
      expect_result("len17", 0, 1);

      uart_in = 1'b0;
      repeat (2) @(negedge clk);
      uart_in = 1'b1;
      expect_result("glitch", 0, 0);

      pq = {8'h13, 8'h03};
      send_q(pq);
      send_byte(8'h07, 1'b0);
      expect_result("stopbit", 0, 1);

      pq = {8'h13, 8'h03, 8'h07};
      send_q(pq);
      idle_bits(30);
      chk("tmo_early", ne - ne0, 0);
      chk("tmo_busy_early", 32'(busy), 32'd1);
      idle_bits(15);
      expect_result("timeout", 0, 1);

      pq = {8'h13, 8'h03, 8'h07};
      send_q(pq);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_id = '0; exp_data = '0;
      chk("mrst_fv", 32'(frame_valid), 32'd0);
      chk("mrst_fe", 32'(frame_error), 32'd0);
      idle_bits(45);
      expect_result("midrst", 0, 0);
      pq = {8'h13, 8'h03, 8'h07, 8'h12, 8'h34, 8'h9D};
      send_q(pq);
      exp_id = 8'h07; exp_data = 16'h1234;
      expect_result("post_rst", 1, 0);

      for (int k = 0; k < 15; k++) begin
         int n;
         logic [7:0] s, b, cs;
         n = $urandom_range(0, MAXL + 3);
         pq = {};
         pq.push_back(8'h13);
         pq.push_back(8'(n));
         if (n >= 1 && n <= MAXL) begin
            s = 8'h13 + 8'(n);
            for (int i = 0; i < n; i++) begin
               b = 8'($urandom);
               pq.push_back(b);
               s = s + b;
            end
            cs = 8'h00 - s;
            if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
            pq.push_back(cs);
         end
         ref_model(pq, ev, ee);
         send_q(pq);
         expect_result("rand", ev, ee);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
